// File: rtl/button_pio_pkg.sv
// Shared constants for the debounced button PIO.
// Register word addresses and edge-type encodings.
package button_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RAW  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int THR_MIN = 2;

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-FF synchroniser, stability counter, accepted level.
// Level is accepted after the input differs from it for limit+1 cycles.
module button_debounce #(
  parameter int CNT_W       = 16,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             din,
  input  logic [CNT_W-1:0] limit,
  output logic             sync,
  output logic             stable
);

  logic             meta;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_LEVEL;
      sync <= RESET_LEVEL;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

  // Any return to the accepted level restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= RESET_LEVEL;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (cnt == limit) begin
      stable <= sync;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/button_pio_debounced.sv
// Avalon-MM button PIO with debounce, edge capture (W1C) and masked irq.
// BUTTON_DBNC_PROG_EN: address 1 becomes a R/W debounce threshold.
module button_pio_debounced
  import button_pio_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int EDGE_TYPE       = 0,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  localparam logic [CNT_W-1:0] DBNC_DEF = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DBNC_MIN = CNT_W'(THR_MIN);

  logic             wr;
  logic [CNT_W-1:0] thr;
  logic [CNT_W-1:0] limit;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [31:0]      rd_mux;

  assign wr    = chipselect && !write_n;
  assign limit = thr - 1'b1;

`ifdef BUTTON_DBNC_PROG_EN
  logic [CNT_W-1:0] thr_wd;
  logic             unused_sig;

  assign thr_wd     = writedata[CNT_W-1:0];
  assign unused_sig = &{1'b0, writedata, sync};

  // Too small a threshold would let single-cycle glitches through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thr <= DBNC_DEF;
    end else if (wr && address == ADDR_RAW) begin
      thr <= (thr_wd < DBNC_MIN) ? DBNC_MIN : thr_wd;
    end
  end
`else
  logic unused_sig;

  assign thr        = DBNC_DEF;
  assign unused_sig = &{1'b0, writedata, DBNC_MIN};
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    button_debounce #(
      .CNT_W      (CNT_W),
      .RESET_LEVEL(RESET_LEVEL)
    ) u_dbnc (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .limit  (limit),
      .sync   (sync[i]),
      .stable (stable[i])
    );
  end

  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

  always_comb begin
    ev = rise;
    case (EDGE_TYPE)
      EDGE_FALL: ev = fall;
      EDGE_ANY:  ev = rise | fall;
      default:   ev = rise;
    endcase
  end

  always_comb begin
    clr = '0;
    if (wr && address == ADDR_EDGE) begin
      clr = writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = stable;
`ifdef BUTTON_DBNC_PROG_EN
      ADDR_RAW:  rd_mux[CNT_W-1:0] = thr;
`else
      ADDR_RAW:  rd_mux[WIDTH-1:0] = sync;
`endif
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
      default:   rd_mux = '0;
    endcase
  end

  // stable_d resets to the same level as stable: no edge on release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d     <= {WIDTH{RESET_LEVEL}};
      irq_mask     <= '0;
      edge_capture <= '0;
      irq          <= 1'b0;
      readdata     <= '0;
    end else begin
      stable_d <= stable;
      if (wr && address == ADDR_MASK) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      edge_capture <= (edge_capture & ~clr) | ev;
      irq          <= |(edge_capture & irq_mask);
      readdata     <= rd_mux;
    end
  end

endmodule
